// File: rtl/alu_mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer_if
// Shared-ALU access bus used by the multiply sequencer.
//   alu_req  : sequencer wants the ALU this cycle
//   alu_gnt  : ALU is owned by the sequencer this cycle
//   alu_a/b  : ALU operands (8 bit)
//   alu_ctrl : ALU opcode (4'b0010 ADD, 4'b0111 RRC, 4'b0000 idle)
//   alu_cin  : ALU carry-in
//   alu_out  : ALU result, combinational in the same cycle
//   alu_cout : ALU carry-out, combinational in the same cycle
// master = the sequencer, slave = the ALU / arbiter side.
// -----------------------------------------------------------------------------
interface alu_mul_sequencer_if;
    logic       alu_req;
    logic       alu_gnt;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_ctrl;
    logic       alu_cin;
    logic [7:0] alu_out;
    logic       alu_cout;

    modport master (
        output alu_req, alu_a, alu_b, alu_ctrl, alu_cin,
        input  alu_gnt, alu_out, alu_cout
    );

    modport slave (
        input  alu_req, alu_a, alu_b, alu_ctrl, alu_cin,
        output alu_gnt, alu_out, alu_cout
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
// Unsigned 8x8 -> 16 multiply performed on a shared 8-bit ALU using a
// shift-add sequence: per iteration one conditional ADD followed by a 17-bit
// rotate-right of {c, p_hi, p_lo} done as two RRC operations. 8 iterations,
// 24 granted ALU cycles in total.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start, op_a/op_b : launch request and operands (sampled only in IDLE)
//   busy, done       : sequence running / one-cycle completion pulse
//   result_hi/lo     : product, held until the next completed multiply
//   result_zero      : product == 0
//   alu              : shared ALU bus (master side)
// -----------------------------------------------------------------------------
module alu_mul_sequencer (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  op_a,
    input  logic [7:0]                  op_b,
    output logic                        busy,
    output logic                        done,
    output logic [7:0]                  result_hi,
    output logic [7:0]                  result_lo,
    output logic                        result_zero,
    alu_mul_sequencer_if.master         alu
);
    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_RRC  = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_RRC_HI,
        S_RRC_LO,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mcand_q, mcand_d;
    logic [7:0] p_hi_q, p_hi_d;
    logic [7:0] p_lo_q, p_lo_d;
    logic       c_q, c_d;
    logic [2:0] iter_q, iter_d;
    logic [7:0] result_hi_q, result_hi_d;
    logic [7:0] result_lo_q, result_lo_d;
    logic       result_zero_q, result_zero_d;

    logic [7:0] alu_a_c;
    logic [7:0] alu_b_c;
    logic [3:0] alu_ctrl_c;
    logic       alu_cin_c;
    logic       busy_c;
    logic       done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mcand_q       <= 8'h00;
            p_hi_q        <= 8'h00;
            p_lo_q        <= 8'h00;
            c_q           <= 1'b0;
            iter_q        <= 3'd0;
            result_hi_q   <= 8'h00;
            result_lo_q   <= 8'h00;
            result_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            p_hi_q        <= p_hi_d;
            p_lo_q        <= p_lo_d;
            c_q           <= c_d;
            iter_q        <= iter_d;
            result_hi_q   <= result_hi_d;
            result_lo_q   <= result_lo_d;
            result_zero_q <= result_zero_d;
        end
    end

    // ALU drive depends only on state and registers, so a stalled cycle
    // (alu_gnt=0) naturally presents identical operands next cycle.
    always_comb begin
        state_d       = state_q;
        mcand_d       = mcand_q;
        p_hi_d        = p_hi_q;
        p_lo_d        = p_lo_q;
        c_d           = c_q;
        iter_d        = iter_q;
        result_hi_d   = result_hi_q;
        result_lo_d   = result_lo_q;
        result_zero_d = result_zero_q;
        alu_a_c       = 8'h00;
        alu_b_c       = 8'h00;
        alu_ctrl_c    = OP_NONE;
        alu_cin_c     = 1'b0;
        busy_c        = 1'b0;
        done_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    p_hi_d  = 8'h00;
                    p_lo_d  = op_b;
                    c_d     = 1'b0;
                    iter_d  = 3'd0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                busy_c     = 1'b1;
                alu_ctrl_c = OP_ADD;
                alu_a_c    = p_hi_q;
                alu_b_c    = p_lo_q[0] ? mcand_q : 8'h00;
                if (alu.alu_gnt) begin
                    p_hi_d  = alu.alu_out;
                    c_d     = alu.alu_cout;
                    state_d = S_RRC_HI;
                end
            end
            S_RRC_HI: begin
                busy_c     = 1'b1;
                alu_ctrl_c = OP_RRC;
                alu_b_c    = p_hi_q;
                alu_cin_c  = c_q;
                if (alu.alu_gnt) begin
                    p_hi_d  = alu.alu_out;
                    c_d     = alu.alu_cout;
                    state_d = S_RRC_LO;
                end
            end
            S_RRC_LO: begin
                busy_c     = 1'b1;
                alu_ctrl_c = OP_RRC;
                alu_b_c    = p_lo_q;
                alu_cin_c  = c_q;
                if (alu.alu_gnt) begin
                    p_lo_d = alu.alu_out;
                    c_d    = 1'b0;
                    iter_d = iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
                        // Final low byte comes straight off the ALU; the
                        // high byte was already settled by the last RRC_HI.
                        result_hi_d   = p_hi_q;
                        result_lo_d   = alu.alu_out;
                        result_zero_d = ~|{p_hi_q, alu.alu_out};
                        state_d       = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = busy_c;
    assign done         = done_c;
    assign result_hi    = result_hi_q;
    assign result_lo    = result_lo_q;
    assign result_zero  = result_zero_q;
    assign alu.alu_req  = busy_c;
    assign alu.alu_a    = alu_a_c;
    assign alu.alu_b    = alu_b_c;
    assign alu.alu_ctrl = alu_ctrl_c;
    assign alu.alu_cin  = alu_cin_c;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       result_zero;

    alu_mul_sequencer_if alu_bus ();

    alu_mul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .result_zero(result_zero),
        .alu        (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model: ADD with carry, RRC = rotate right through carry.
    always_comb begin
        alu_bus.alu_out  = 8'h00;
        alu_bus.alu_cout = 1'b0;
        case (alu_bus.alu_ctrl)
            4'b0010: {alu_bus.alu_cout, alu_bus.alu_out} =
                         {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b} + {8'h00, alu_bus.alu_cin};
            4'b0111: begin
                alu_bus.alu_out  = {alu_bus.alu_cin, alu_bus.alu_b[7:1]};
                alu_bus.alu_cout = alu_bus.alu_b[0];
            end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;
    int gnt_mode = 0;          // 0: always granted, 1: toggle starting with 0
    logic [15:0] exp_q[$];

    // Drives start across edge N; returns at N+1 (+1) with gnt set for cycle 1.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        exp_q.push_back(16'(a) * 16'(b));
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        alu_bus.alu_gnt = (gnt_mode == 0);
    endtask

    // Waits for done; cyc is the cycle index relative to the accepting edge.
    task automatic wait_done(output int cyc);
        cyc = 1;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            alu_bus.alu_gnt = (gnt_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        end while (!done && cyc < 300);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        op_a = 8'h00;
        op_b = 8'h00;
        alu_bus.alu_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({busy, done, alu_bus.alu_req, result_zero} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got busy=%b done=%b req=%b zero=%b want 0000",
                     busy, done, alu_bus.alu_req, result_zero);
        end
        total++;
        if ({result_hi, result_lo} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_result got %h want 0000", {result_hi, result_lo});
        end
        total++;
        if ({alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_ctrl, alu_bus.alu_cin} !== 21'h0) begin
            bad++;
            $display("FAIL reset_alu got a=%h b=%h ctrl=%h cin=%b want zeros",
                     alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_ctrl, alu_bus.alu_cin);
        end
        $display("reset: busy=%b done=%b result=%h", busy, done, {result_hi, result_lo});
    endtask

    task automatic test_mul(input logic [7:0] a, input logic [7:0] b, input int want_cyc);
        int cyc;
        logic [15:0] exp_v;
        launch(a, b);
        total++;
        if (busy !== 1'b1 || alu_bus.alu_req !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start %h*%h got busy=%b req=%b want 1", a, b, busy, alu_bus.alu_req);
        end
        wait_done(cyc);
        exp_v = exp_q.pop_front();
        total++;
        if (cyc !== want_cyc) begin
            bad++;
            $display("FAIL latency %h*%h got %0d want %0d", a, b, cyc, want_cyc);
        end
        total++;
        if ({result_hi, result_lo} !== exp_v) begin
            bad++;
            $display("FAIL product %h*%h got %h want %h", a, b, {result_hi, result_lo}, exp_v);
        end
        total++;
        if (result_zero !== (exp_v == 16'h0000) || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_busy %h*%h got zero=%b busy=%b want zero=%b busy=0",
                     a, b, result_zero, busy, exp_v == 16'h0000);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || {result_hi, result_lo} !== exp_v) begin
            bad++;
            $display("FAIL done_pulse %h*%h got done=%b result=%h want done=0 result=%h",
                     a, b, done, {result_hi, result_lo}, exp_v);
        end
        $display("mul %h*%h -> %h zero=%b latency=%0d", a, b, {result_hi, result_lo}, result_zero, cyc);
    endtask

    // Alternating grant: every ungranted cycle must leave the ALU drive unchanged.
    task automatic test_stall;
        int cyc;
        int stall_bad;
        logic [20:0] snap;
        logic [15:0] exp_v;
        gnt_mode = 1;
        launch(8'h12, 8'h34);
        cyc = 1;
        stall_bad = 0;
        while (!done && cyc < 300) begin
            snap = {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_ctrl, alu_bus.alu_cin};
            if (!alu_bus.alu_gnt) begin
                @(posedge clk);
                #1;
                cyc++;
                total++;
                if (busy && snap !== {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_ctrl, alu_bus.alu_cin}) begin
                    bad++;
                    stall_bad++;
                    if (stall_bad < 4)
                        $display("FAIL stall_hold cycle %0d got %h want %h", cyc,
                                 {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_ctrl, alu_bus.alu_cin}, snap);
                end
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
            alu_bus.alu_gnt = ((cyc % 2) == 0);
        end
        exp_v = exp_q.pop_front();
        total++;
        if (cyc !== 49) begin
            bad++;
            $display("FAIL stall_latency got %0d want 49", cyc);
        end
        total++;
        if ({result_hi, result_lo} !== exp_v) begin
            bad++;
            $display("FAIL stall_product got %h want %h", {result_hi, result_lo}, exp_v);
        end
        $display("stall mul 12*34 -> %h latency=%0d", {result_hi, result_lo}, cyc);
        gnt_mode = 0;
        alu_bus.alu_gnt = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort;
        launch(8'hAA, 8'h55);
        repeat (13) @(posedge clk);  // into iteration 4
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        total++;
        if (busy !== 1'b0 || alu_bus.alu_req !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_flags got busy=%b req=%b done=%b want 0", busy, alu_bus.alu_req, done);
        end
        total++;
        if ({result_hi, result_lo, result_zero} !== 17'h0) begin
            bad++;
            $display("FAIL abort_result got %h zero=%b want 0000 zero=0", {result_hi, result_lo}, result_zero);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet cycle %0d got done=%b busy=%b want 0", i, done, busy);
            end
        end
        $display("abort: busy=%b result=%h", busy, {result_hi, result_lo});
        test_mul(8'hAA, 8'h55, 25);
    endtask

    // start pulses while busy and while in DONE must be ignored.
    task automatic test_back_to_back;
        int cyc;
        logic [15:0] exp_v;
        launch(8'h03, 8'h05);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            start = (cyc == 5);
            op_a  = 8'hFF;
            op_b  = 8'hFF;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        // In DONE now: a start here must not be accepted.
        @(negedge clk);
        start = 1'b1;
        op_a  = 8'h77;
        op_b  = 8'h66;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_v = exp_q.pop_front();
        total++;
        if (cyc !== 25 || {result_hi, result_lo} !== exp_v) begin
            bad++;
            $display("FAIL ignore_start got lat=%0d result=%h want lat=25 result=%h",
                     cyc, {result_hi, result_lo}, exp_v);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_in_done got busy=%b done=%b want 0", busy, done);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle got busy=%b want 0", busy);
        end
        $display("ignored starts: result=%h latency=%0d", {result_hi, result_lo}, cyc);
    endtask

    initial begin
        test_reset();
        test_mul(8'h0F, 8'h0F, 25);
        test_mul(8'hFF, 8'hFF, 25);
        total++;
        if (result_hi[7] !== 1'b1) begin
            bad++;
            $display("FAIL bit15 got %b want 1", result_hi[7]);
        end
        test_mul(8'h00, 8'h5A, 25);
        test_stall();
        test_abort();
        test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            test_mul(8'($urandom), 8'($urandom), 25);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
